// File: rtl/rv32_mod_fetch.sv
// rtl/rv32_mod_fetch.sv - rv32imc fetch stage: PC sequencing, word fetch, 16/32-bit instruction assembly
module rv32_mod_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c,
  output logic        fault
);

  typedef enum logic [1:0] {S_REQ_LO, S_REQ_HI, S_HOLD, S_FAULT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [29:0] r_buf_addr;
  logic [31:0] r_buf_data;
  logic        r_buf_valid;
  logic [15:0] r_stash;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_is_c;
  logic        r_fault;

  logic [15:0] w_fetch_half;
  logic        w_fetch_is_c;
  logic [31:0] w_next_pc;
  logic [15:0] w_buf_half;
  logic        w_buf_half_is_c;
  logic        w_buf_hit;

  assign w_fetch_half    = r_pc[1] ? imem_rdata[31:16] : imem_rdata[15:0];
  assign w_fetch_is_c    = (w_fetch_half[1:0] != 2'b11);
  assign w_next_pc       = branch_taken ? branch_target
                                        : r_pc + (r_instr_is_c ? 32'd2 : 32'd4);
  assign w_buf_half      = w_next_pc[1] ? r_buf_data[31:16] : r_buf_data[15:0];
  assign w_buf_half_is_c = (w_buf_half[1:0] != 2'b11);
  assign w_buf_hit       = r_buf_valid && (w_next_pc[31:2] == r_buf_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ_LO;
      r_pc          <= RESET_VECTOR;
      r_buf_addr    <= '0;
      r_buf_data    <= '0;
      r_buf_valid   <= 1'b0;
      r_stash       <= '0;
      r_req         <= 1'b0;
      r_addr        <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_is_c  <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_REQ_LO: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_addr <= {r_pc[31:2], 2'b00};
          end else if (imem_ack) begin
            r_req <= 1'b0;
            if (imem_err) begin
              r_state       <= S_FAULT;
              r_fault       <= 1'b1;
              r_buf_valid   <= 1'b0;
              r_instr_valid <= 1'b0;
              r_instr_pc    <= r_pc;
            end else begin
              r_buf_addr  <= r_addr[31:2];
              r_buf_data  <= imem_rdata;
              r_buf_valid <= 1'b1;
              if (w_fetch_is_c || !r_pc[1]) begin
                r_instr       <= w_fetch_is_c ? {16'h0, w_fetch_half} : imem_rdata;
                r_instr_is_c  <= w_fetch_is_c;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_state       <= S_HOLD;
              end else begin
                // Upper half of this word starts a 32-bit instruction; fetch the next word.
                r_stash <= w_fetch_half;
                r_state <= S_REQ_HI;
              end
            end
          end
        end
        S_REQ_HI: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_addr <= {r_pc[31:2] + 30'd1, 2'b00};
          end else if (imem_ack) begin
            r_req <= 1'b0;
            if (imem_err) begin
              r_state       <= S_FAULT;
              r_fault       <= 1'b1;
              r_buf_valid   <= 1'b0;
              r_instr_valid <= 1'b0;
              r_instr_pc    <= r_pc;
            end else begin
              r_buf_addr    <= r_addr[31:2];
              r_buf_data    <= imem_rdata;
              r_buf_valid   <= 1'b1;
              r_instr       <= {imem_rdata[15:0], r_stash};
              r_instr_is_c  <= 1'b0;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (advance) begin
            if (w_next_pc[0]) begin
              r_state       <= S_FAULT;
              r_fault       <= 1'b1;
              r_buf_valid   <= 1'b0;
              r_instr_valid <= 1'b0;
              r_instr_pc    <= w_next_pc;
            end else begin
              r_pc <= w_next_pc;
              if (w_buf_hit && (w_buf_half_is_c || !w_next_pc[1])) begin
                r_instr      <= w_buf_half_is_c ? {16'h0, w_buf_half} : r_buf_data;
                r_instr_is_c <= w_buf_half_is_c;
                r_instr_pc   <= w_next_pc;
              end else if (w_buf_hit) begin
                r_stash       <= w_buf_half;
                r_req         <= 1'b1;
                r_addr        <= {w_next_pc[31:2] + 30'd1, 2'b00};
                r_instr_valid <= 1'b0;
                r_state       <= S_REQ_HI;
              end else begin
                r_req         <= 1'b1;
                r_addr        <= {w_next_pc[31:2], 2'b00};
                r_instr_valid <= 1'b0;
                r_state       <= S_REQ_LO;
              end
            end
          end
        end
        default: begin
          r_req         <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_is_c  = r_instr_is_c;
  assign fault       = r_fault;

endmodule

// File: doc/rv32_mod_fetch.md
Name: rv32_mod_fetch

Overview:
Instruction fetch / PC-sequencing stage of the rv32imc single-stage core. It holds the architectural PC and consumes the branch unit's branch_taken plus the computed target to select the next PC. It fetches aligned words over a req/ack instruction bus, assembles 16-bit (C) and 32-bit instructions, including 32-bit instructions that straddle a word boundary, and presents one instruction at a time to decode and execute.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset; bit 0 must be 0.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request; held until imem_ack
imem_addr  output  32  word-aligned fetch address, bits [1:0] always 0
imem_ack  input  1  request complete; imem_rdata/imem_err valid this cycle
imem_rdata  input  32  fetched word, little-endian halfwords
imem_err  input  1  bus error qualifier on imem_ack
advance  input  1  core retires current instruction this cycle; ignored when instr_valid=0
branch_taken  input  1  from branch unit; sampled only with advance
branch_target  input  32  next PC when branch_taken
instr_valid  output  1  instr/instr_pc/instr_is_c valid
instr  output  32  instruction; compressed ones zero-extended to {16'h0, half}
instr_pc  output  32  PC of instr
instr_is_c  output  1  instr is 16-bit (half[1:0] != 2'b11)
fault  output  1  sticky fetch fault (misaligned target or bus error)

Behaviour:
- Reset (rst=1 on an edge): pc=RESET_VECTOR; buffer invalid; state REQ_LO; imem_req=0, instr_valid=0, instr=0, instr_pc=0, instr_is_c=0, fault=0. Reset mid-transaction abandons it; any ack arriving during or after reset for that request is ignored.
- States: REQ_LO (fetch the word containing pc), REQ_HI (fetch word pc+2 for upper half of a straddling instr), HOLD (instr_valid=1, waiting for advance), FAULT.
- Word buffer: buf_addr[31:2], buf_data[31:0], buf_valid. Every successful ack loads it. Invalidated only by rst and on entry to FAULT. No coherence with stores.
- Bus: imem_req=1 only in REQ_LO/REQ_HI. imem_addr is stable while imem_req=1. Ack may arrive in the first req cycle or any later cycle. imem_req drops the cycle after ack.
- Assembly at pc, with W = word at pc[31:2]:
  - pc[1]=0: half=W[15:0]. If compressed, instr={16'h0,half}; else instr=W.
  - pc[1]=1: half=W[31:16]. If compressed, instr={16'h0,half}; else stash half and go to REQ_HI at {pc[31:2]+1,2'b00}. Then instr={rdata[15:0],stash}.
- Latency: ack in cycle t -> instr_valid=1 in t+1, state HOLD.
- On advance in HOLD:
  - next_pc = branch_taken ? branch_target : pc + (instr_is_c ? 2 : 4), 32-bit wrap.
  - If next_pc[0]=1: enter FAULT.
  - Else if next_pc word == buf_addr, buf_valid, and the instruction is fully contained in that word: instr_valid stays 1 and the new instr appears next cycle (zero bubble, no request).
  - Else if next_pc[1]=1, its word hits the buffer, and the half is a 32-bit low half: REQ_HI directly.
  - Otherwise: instr_valid=0 next cycle and REQ_LO.
- branch_target is ignored when branch_taken=0 or advance=0. advance with instr_valid=0 has no effect.
- imem_err with imem_ack: enter FAULT.
- FAULT: fault=1, instr_valid=0, imem_req=0, instr_pc=offending PC (target or fetch PC). Exit only via rst.
- The straddle fetch crossing 32'hFFFF_FFFC wraps to 0.

Test Plan:
1. RESET_VECTOR=32'h80, release rst -> next cycle imem_req=1, imem_addr=32'h80. Ack after 3 cycles with 32'h00A00093 -> addr stable while waiting; instr_valid=1, instr=32'h00A00093, instr_pc=32'h80, instr_is_c=0.
2. Word at 0x80 = 32'h4505_4081, advance twice -> instr=32'h0000_4081 pc 0x80, then 32'h0000_4505 pc 0x82 with no imem_req and no bubble. Next advance requests 0x84.
3. Straddle: word 0x80 = 32'h0093_4081, word 0x84 = 32'h0000_00A0. After advancing past c-instr -> imem_addr=0x84 (REQ_HI); instr=32'h00A00093, pc 0x82, is_c=0. Following advance yields pc 0x86 from buffer, no request.
4. advance with branch_taken=1, branch_target=32'h100 -> instr_valid=0, imem_addr=32'h100 next cycle. Same with branch_taken=0, target 32'h200 -> pc+4, target ignored.
5. advance, branch_taken=1, target 32'h101 -> fault=1, instr_valid=0, imem_req=0, instr_pc=32'h101 until rst. Separately, ack with imem_err=1 -> fault=1.
6. rst asserted while imem_req=1 and ack pending -> imem_req=0 on next cycle. Late ack ignored; after release, fetch restarts at RESET_VECTOR with fault=0.
